// File: rtl/vector_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vector_sequencer
// Brief    : Walks NUM_VEC input vectors onto a DUT, samples each response after
//            a settle time and reports error count, first failing step and pass.
//            Define VECTOR_SEQUENCER_GRAY_EN to apply the vectors in Gray order.
// Revision : 1.0 - initial release
// ============================================================================
module vector_sequencer #(
    parameter int                         IN_W        = 3,
    parameter int                         OUT_W       = 1,
    parameter int                         NUM_VEC     = 8,
    parameter int                         SETTLE      = 2,
    parameter int                         CNT_W       = 16,
    parameter logic [NUM_VEC*OUT_W-1:0]   EXP_PATTERN = 8'hAE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    output logic [IN_W-1:0]              dut_in,
    input  logic [OUT_W-1:0]             dut_out,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [CNT_W-1:0]             err_cnt,
    output logic                         fail_valid,
    output logic [$clog2(NUM_VEC)-1:0]   fail_idx
);

    localparam int c_STEP_W   = $clog2(NUM_VEC);
    localparam int c_SETTLE_W = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [IN_W-1:0]         r_dut_in;
    logic                    r_pass;
    logic [CNT_W-1:0]        r_err_cnt;
    logic                    r_fail_valid;
    logic [c_STEP_W-1:0]     r_fail_idx;
    logic [c_STEP_W-1:0]     r_step;
    logic [c_SETTLE_W-1:0]   r_settle;
    logic [OUT_W-1:0]        w_exp;
    logic                    w_mismatch;
    logic                    w_last;
    logic                    w_settled;

    // Vector applied at step k: binary k, or its Gray code when enabled.
    function automatic logic [IN_W-1:0] f_vec(input logic [c_STEP_W-1:0] k);
        logic [IN_W-1:0] v;
        v = '0;
        v[c_STEP_W-1:0] = k;
`ifdef VECTOR_SEQUENCER_GRAY_EN
        v = v ^ (v >> 1);
`endif
        return v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        busy       = 1'b0;
        done       = 1'b0;
        w_exp      = EXP_PATTERN[int'(r_step)*OUT_W +: OUT_W];
        w_mismatch = (dut_out != w_exp);
        w_last     = (r_step == c_STEP_W'(NUM_VEC - 1));
        w_settled  = (r_settle == c_SETTLE_W'(SETTLE - 1));
        case (r_state)
            S_IDLE: begin
                if (start && !abort) w_next = S_SETTLE;
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (abort)          w_next = S_IDLE;
                else if (w_settled) w_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                busy = 1'b1;
                if (abort)       w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
                else             w_next = S_SETTLE;
            end
            S_DONE: begin
                done   = !abort;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Abort leaves counters and dut_in frozen; only pass is forced low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dut_in     <= '0;
            r_pass       <= 1'b0;
            r_err_cnt    <= '0;
            r_fail_valid <= 1'b0;
            r_fail_idx   <= '0;
            r_step       <= '0;
            r_settle     <= '0;
        end else if (abort) begin
            r_pass <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dut_in     <= f_vec('0);
                        r_pass       <= 1'b0;
                        r_err_cnt    <= '0;
                        r_fail_valid <= 1'b0;
                        r_fail_idx   <= '0;
                        r_step       <= '0;
                        r_settle     <= '0;
                    end
                end
                S_SETTLE: begin
                    r_settle <= r_settle + c_SETTLE_W'(1);
                end
                S_SAMPLE: begin
                    if (w_mismatch) begin
                        if (r_err_cnt != {CNT_W{1'b1}}) r_err_cnt <= r_err_cnt + CNT_W'(1);
                        if (!r_fail_valid) begin
                            r_fail_valid <= 1'b1;
                            r_fail_idx   <= r_step;
                        end
                    end
                    if (!w_last) begin
                        r_dut_in <= f_vec(r_step + c_STEP_W'(1));
                        r_step   <= r_step + c_STEP_W'(1);
                        r_settle <= '0;
                    end
                end
                S_DONE: begin
                    r_pass <= !r_fail_valid;
                end
                default: ;
            endcase
        end
    end

    assign dut_in     = r_dut_in;
    assign pass       = r_pass;
    assign err_cnt    = r_err_cnt;
    assign fail_valid = r_fail_valid;
    assign fail_idx   = r_fail_idx;

endmodule
`default_nettype wire

// File: tb/tb_vector_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for vector_sequencer: randomized and directed runs checked cycle by cycle
// against a step-level reference model, plus a CNT_W=2 instance for saturation.
module tb_vector_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  dut_in;
    logic [0:0]  dut_out = 1'b0;
    logic        busy, done, pass, fail_valid;
    logic [15:0] err_cnt;
    logic [2:0]  fail_idx;

    logic        start2 = 1'b0;
    logic [2:0]  dut_in2;
    logic [0:0]  dut_out2 = 1'b0;
    logic        busy2, done2, pass2, fail_valid2;
    logic [1:0]  err_cnt2;
    logic [2:0]  fail_idx2;

    logic [7:0]  exp_pat = 8'hAE;
    int          n_checks = 0;
    int          n_errs = 0;

    always #5 clk = ~clk;

    vector_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt), .fail_valid(fail_valid), .fail_idx(fail_idx)
    );

    vector_sequencer #(.CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
        .dut_in(dut_in2), .dut_out(dut_out2), .busy(busy2), .done(done2),
        .pass(pass2), .err_cnt(err_cnt2), .fail_valid(fail_valid2), .fail_idx(fail_idx2)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int vec(input int k);
`ifdef VECTOR_SEQUENCER_GRAY_EN
        return k ^ (k >> 1);
`else
        return k;
`endif
    endfunction

    // mode 0: mock returns expected, 1: stuck-at-0, 2: stuck-at-1, 3: random responses
    task automatic run_seq(input int mode, input logic [7:0] rnd, input int abort_cyc,
                           input bit repulse, input bit sat_run);
        logic [7:0] rbits;
        int         stop, errs, fidx, eff, sc;
        bit         fv;
        case (mode)
            0:       rbits = exp_pat;
            1:       rbits = 8'h00;
            2:       rbits = 8'hFF;
            default: rbits = rnd;
        endcase
        stop   = (abort_cyc > 0) ? abort_cyc : 1000;
        start  = 1'b1;
        start2 = sat_run;
        for (int c = 1; c <= 27; c++) begin
            @(posedge clk); #1;
            start  = repulse && (c == 5 || c == 24 || c == 25);
            start2 = 1'b0;
            abort  = (c == abort_cyc);
            if (c % 3 == 0 && c <= 24) dut_out = rbits[c/3-1];
            else if (mode == 1)        dut_out = 1'b0;
            else if (mode == 2)        dut_out = 1'b1;
            else                       dut_out = 1'($urandom_range(0, 1));
            @(negedge clk);
            errs = 0; fv = 0; fidx = 0;
            for (int k = 0; k < 8; k++) begin
                sc = (k + 1) * 3;
                if (sc < c && sc < stop && rbits[k] != exp_pat[k]) begin
                    if (!fv) fidx = k;
                    fv = 1;
                    errs++;
                end
            end
            eff = (abort_cyc > 0 && c > stop) ? stop : ((c > 24) ? 24 : c);
            check($sformatf("busy c%0d", c), busy, (c <= 24 && c <= stop));
            check($sformatf("done c%0d", c), done, (abort_cyc == 0 && c == 25));
            check($sformatf("dut_in c%0d", c), dut_in, vec((eff - 1) / 3));
            check($sformatf("err_cnt c%0d", c), err_cnt, errs);
            check($sformatf("fail_valid c%0d", c), fail_valid, fv);
            check($sformatf("pass c%0d", c), pass, (abort_cyc == 0 && c >= 26 && errs == 0));
            if (fv) check($sformatf("fail_idx c%0d", c), fail_idx, fidx);
        end
        start = 1'b0;
        abort = 1'b0;
        if (sat_run) begin
            check("sat err_cnt", err_cnt2, 3);
            check("sat pass", pass2, 0);
            check("sat fail_valid", fail_valid2, 1);
        end
    endtask

    initial begin
        logic [7:0] rnd;
        int         ab;

        repeat (2) @(posedge clk);
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst dut_in", dut_in, 0);
        check("rst err_cnt", err_cnt, 0);
        check("rst pass", pass, 0);
        check("rst fail_valid", fail_valid, 0);
        check("rst fail_idx", fail_idx, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_seq(0, 8'h00, 0, 0, 0);   // matching mock: pass
        run_seq(1, 8'h00, 0, 0, 1);   // stuck-at-0: 5 errors, first at step 1
        check("stuck0 final err_cnt", err_cnt, 5);
        check("stuck0 final fail_idx", fail_idx, 1);

        // abort together with start while idle: nothing starts, counters held
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle abort busy", busy, 0);
            check("idle abort err_cnt", err_cnt, 5);
            check("idle abort fail_idx", fail_idx, 1);
        end

        run_seq(2, 8'h00, 0, 0, 0);   // stuck-at-1: 3 errors, first at step 0
        run_seq(1, 8'h00, 10, 0, 0);  // abort at cycle 10: err_cnt frozen at 2
        check("abort frozen err_cnt", err_cnt, 2);
        run_seq(0, 8'h00, 0, 0, 0);   // fresh start clears, full run
        run_seq(0, 8'h00, 0, 1, 0);   // start re-pulsed mid-run and in DONE

        // asynchronous reset in the middle of a run
        dut_out = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check("pre-rst err_cnt", err_cnt, 1);
        check("pre-rst dut_in", dut_in, vec(1));
        rst = 1'b1;
        #1;
        check("async rst busy", busy, 0);
        check("async rst dut_in", dut_in, 0);
        check("async rst err_cnt", err_cnt, 0);
        check("async rst fail_valid", fail_valid, 0);
        check("async rst fail_idx", fail_idx, 0);
        check("async rst pass", pass, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post-rst busy", busy, 0);
            check("post-rst dut_in", dut_in, 0);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            rnd = 8'($urandom);
            ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 24)) : 0;
            run_seq(3, rnd, ab, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
